// File: rtl/hazard_ctrl_pkg.sv
// Shared processor definitions for the pipeline hazard/stall controller:
// controller state encoding, register-number width, the bank control
// payload and the RUN-priority helper shared by RUN and DWAIT.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W = 3;
    localparam int unsigned ST_W  = 2;
    localparam int unsigned WD_W  = 8;

    localparam logic [ST_W-1:0] ST_RUN   = 2'd0;
    localparam logic [ST_W-1:0] ST_DWAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_HALT  = 2'd2;

    // Write enables and bubble-inserts for the five pipeline register banks
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } bank_ctrl_t;

    localparam bank_ctrl_t CTRL_FREEZE = bank_ctrl_t'(7'b00000_00);
    localparam bank_ctrl_t CTRL_FLOW   = bank_ctrl_t'(7'b11111_00);

    // Branch > load-use > fetch stall > free flow
    function automatic bank_ctrl_t run_ctrl(input logic branch_taken,
                                            input logic load_use,
                                            input logic imem_ready);
        bank_ctrl_t c;
        c = CTRL_FLOW;
        if (branch_taken) begin
            // PC is redirected even if the fetch is stalled
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end else if (!imem_ready) begin
            c.pc_en      = 1'b0;
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with increment enable.
// Ports: clk, rst_n (async active-low clear), inc_i (count this cycle),
//        cnt_o (current count, holds at all-ones).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 16-bit five-stage core.
// Drives bank write enables / flushes (Mealy, zero-cycle) resolving
// load-use, taken branches, imem/dmem wait states and halt; keeps a
// data-memory watchdog and a saturating stall-cycle counter.
// Ports: clk, rst (async active-low); ID/EX hazard inputs id_rs1/2,
//        id_uses_rs1/2, ex_memread, ex_rd, ex_branch_taken; memory
//        handshakes imem_ready, dmem_req, dmem_ready; wb_halt.
//        Outputs pc/ifid/idex/exmem/memwb_en, ifid/idex_flush, halted,
//        dmem_fault (sticky), stall_cnt.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             dmem_fault,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(DMEM_TIMEOUT);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

    logic [ST_W-1:0] state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            fault_q, fault_d;
    logic [WD_W-1:0] wd_inc;
    logic            load_use;
    bank_ctrl_t      run_c;
    bank_ctrl_t      ctrl;
    bank_ctrl_t      ctrl_g;
    logic            stall_inc;

    // Register 0 is an ordinary register here, so no zero check
    assign load_use = ex_memread &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign run_c  = run_ctrl(ex_branch_taken, load_use, imem_ready);
    assign wd_inc = wd_q + WD_ONE;

    // Next-state and bank control
    always_comb begin
        ctrl    = CTRL_FREEZE;
        state_d = state_q;
        wd_d    = wd_q;
        fault_d = fault_q;
        case (state_q)
            ST_RUN: begin
                if (wb_halt) begin
                    state_d = ST_HALT;
                end else if (dmem_req && !dmem_ready) begin
                    // This cycle is wait cycle 1
                    wd_d = WD_ONE;
                    if (WD_LIMIT <= WD_ONE) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_DWAIT;
                    end
                end else begin
                    ctrl = run_c;
                end
            end
            ST_DWAIT: begin
                if (!dmem_ready) begin
                    wd_d = wd_inc;
                    if (wd_inc >= WD_LIMIT) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                end else begin
                    ctrl    = run_c;
                    wd_d    = '0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                // HALT (and the unused encoding) stay frozen until reset
                state_d = ST_HALT;
            end
        endcase
    end

    // Banks must not load while reset is held
    assign ctrl_g = rst ? ctrl : CTRL_FREEZE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end

    // Count PC stalls, including the cycle that enters HALT
    assign stall_inc = !ctrl_g.pc_en && (state_q != ST_HALT);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    assign pc_en      = ctrl_g.pc_en;
    assign ifid_en    = ctrl_g.ifid_en;
    assign idex_en    = ctrl_g.idex_en;
    assign exmem_en   = ctrl_g.exmem_en;
    assign memwb_en   = ctrl_g.memwb_en;
    assign ifid_flush = ctrl_g.ifid_flush;
    assign idex_flush = ctrl_g.idex_flush;
    assign halted     = (state_q == ST_HALT);
    assign dmem_fault = fault_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the stimulus process pushes the
// hand-computed expected outputs of each cycle; a monitor pops and
// compares them at the falling edge.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] FRZ = 7'b00000_00;
    localparam logic [6:0] ALL = 7'b11111_00;
    localparam logic [6:0] LU  = 7'b00111_01;
    localparam logic [6:0] IMS = 7'b01111_10;
    localparam logic [6:0] BR  = 7'b11111_11;

    typedef struct {
        string      name;
        logic [6:0] en;
        logic       halted;
        logic       fault;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken;
    logic       imem_ready, dmem_req, dmem_ready, wb_halt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, halted, dmem_fault;
    logic [CNT_W-1:0] stall_cnt;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .DMEM_TIMEOUT (8),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .imem_ready      (imem_ready),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .wb_halt         (wb_halt),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .halted          (halted),
        .dmem_fault      (dmem_fault),
        .stall_cnt       (stall_cnt)
    );

    task automatic push_exp(input string nm, input logic [6:0] en,
                            input logic h, input logic f, input logic [3:0] c);
        exp_t e;
        e.name   = nm;
        e.en     = en;
        e.halted = h;
        e.fault  = f;
        e.cnt    = c;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 3'd1; id_rs2 = 3'd2; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        ex_memread = 1'b0; ex_rd = 3'd7; ex_branch_taken = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0; wb_halt = 1'b0;
    endtask

    // Monitor: one expectation per cycle in which one was issued
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = exp_q.pop_front();
            act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
            checks++;
            if (act !== e.en || halted !== e.halted || dmem_fault !== e.fault ||
                stall_cnt !== e.cnt) begin
                failures++;
                $display("FAIL %s: got en=%b halted=%b fault=%b cnt=%0d, want en=%b halted=%b fault=%b cnt=%0d",
                         e.name, act, halted, dmem_fault, stall_cnt,
                         e.en, e.halted, e.fault, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", FRZ, 0, 0, 0);
        cyc(); rst = 1'b1; idle();
        push_exp("run_idle", ALL, 0, 0, 0); cyc();

        // Load-use on rs2
        ex_memread = 1; ex_rd = 3'd3; id_rs2 = 3'd3; id_uses_rs2 = 1; id_rs1 = 3'd5;
        push_exp("lu_rs2", LU, 0, 0, 0); cyc(); idle();
        push_exp("after_lu", ALL, 0, 0, 1); cyc();

        // Branch wins over fetch stall
        ex_branch_taken = 1; imem_ready = 0;
        push_exp("br_imem", BR, 0, 0, 1); cyc(); idle();
        push_exp("after_br", ALL, 0, 0, 1); cyc();

        // Matching registers but not used: no hazard
        ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        push_exp("lu_masked", ALL, 0, 0, 1); cyc();
        id_uses_rs1 = 1;
        push_exp("lu_r0_rs1", LU, 0, 0, 1); cyc();
        ex_branch_taken = 1;
        push_exp("br_over_lu", BR, 0, 0, 2); cyc();
        ex_branch_taken = 0; imem_ready = 0;
        push_exp("lu_over_imem", LU, 0, 0, 2); cyc(); idle();
        imem_ready = 0;
        push_exp("imem_stall", IMS, 0, 0, 3); cyc(); idle();
        push_exp("idle2", ALL, 0, 0, 4); cyc();

        // Four-cycle data wait
        dmem_req = 1; dmem_ready = 0;
        push_exp("dwait1", FRZ, 0, 0, 4); cyc();
        push_exp("dwait2", FRZ, 0, 0, 5); cyc();
        push_exp("dwait3", FRZ, 0, 0, 6); cyc();
        push_exp("dwait4", FRZ, 0, 0, 7); cyc();
        dmem_ready = 1;
        push_exp("dwait_done", ALL, 0, 0, 8); cyc(); idle();
        push_exp("idle3", ALL, 0, 0, 8); cyc();

        // Data wait released together with a taken branch
        dmem_req = 1; dmem_ready = 0;
        push_exp("dwait_b", FRZ, 0, 0, 8); cyc();
        dmem_ready = 1; ex_branch_taken = 1;
        push_exp("dwait_br", BR, 0, 0, 9); cyc(); idle();
        push_exp("idle4", ALL, 0, 0, 9); cyc();

        // Watchdog: 8 wait cycles then fault, counter saturates on the way
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 8; i++) begin
            push_exp($sformatf("wd_wait%0d", i + 1), FRZ, 0, 0,
                     4'((9 + i > 15) ? 15 : 9 + i));
            cyc();
        end
        for (int i = 0; i < 20; i++) begin
            ex_branch_taken = i[0];
            dmem_ready      = i[1];
            push_exp($sformatf("wd_halted%0d", i), FRZ, 1, 1, 15);
            cyc();
        end

        // Asynchronous reset mid-cycle while halted
        #2; rst = 1'b0;
        push_exp("rst_in_halt", FRZ, 0, 0, 0);
        cyc(); rst = 1'b1; idle();
        push_exp("run_after_rst", ALL, 0, 0, 0); cyc();
        imem_ready = 0;
        push_exp("imem_stall2", IMS, 0, 0, 0); cyc();

        // Halt outranks a data stall and a branch
        wb_halt = 1; ex_branch_taken = 1; dmem_req = 1;
        push_exp("halt_enter", FRZ, 0, 0, 1); cyc(); idle();
        for (int i = 0; i < 5; i++) begin
            ex_branch_taken = i[0];
            imem_ready      = i[1];
            push_exp($sformatf("halted%0d", i), FRZ, 1, 0, 2);
            cyc();
        end
        #3; rst = 1'b0;
        push_exp("rst_in_halt2", FRZ, 0, 0, 0);
        cyc(); rst = 1'b1; idle();
        push_exp("run_after_rst2", ALL, 0, 0, 0); cyc();

        // Saturation
        imem_ready = 0;
        for (int i = 0; i < 20; i++) begin
            push_exp($sformatf("sat%0d", i), IMS, 0, 0, 4'((i > 15) ? 15 : i));
            cyc();
        end
        idle();
        push_exp("sat_hold", ALL, 0, 0, 15); cyc();
        ex_branch_taken = 1;
        push_exp("sat_br", BR, 0, 0, 15); cyc(); idle();

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
